// File: rtl/mesh_skew_pkg.sv
// Shared widths, per-lane beat record and FSM states for the mesh input skewer.
// The record types here are sized by the default widths; wider builds define matching local records.
package mesh_skew_pkg;

  localparam int A_W     = 8;
  localparam int BD_W    = 20;
  localparam int ID_W    = 3;
  localparam int SHIFT_W = 5;

  typedef struct packed {
    logic               dataflow;
    logic               propagate;
    logic [SHIFT_W-1:0] shift;
  } mesh_ctrl_t;

  typedef struct packed {
    logic            valid;
    logic [A_W-1:0]  a;
    logic [BD_W-1:0] b;
    logic [BD_W-1:0] d;
    logic [ID_W-1:0] id;
    logic            last;
    mesh_ctrl_t      ctrl;
  } lane_beat_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } skew_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage register chain carrying one lane's beat record.
// Every stage shifts every cycle; reset clears the whole chain so nothing in flight survives.
module skew_delay_line #(
  parameter int  DEPTH = 1,
  parameter type T     = mesh_skew_pkg::lane_beat_t
) (
  input  logic clk,
  input  logic rst_n,
  input  T     in_data,
  output T     out_data
);

  T r_stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_stage[k] <= '0;
      end
    end else begin
      r_stage[0] <= in_data;
      for (int k = 1; k < DEPTH; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  assign out_data = r_stage[DEPTH-1];

endmodule

// File: rtl/mesh_input_skewer.sv
// Skews one row-beat per cycle into a diagonal wavefront (lane i delayed i+1 cycles) and
// holds off the next matmul until the final beat of the current one has cleared the last lane.
module mesh_input_skewer #(
  parameter int DIM     = 16,
  parameter int A_W     = mesh_skew_pkg::A_W,
  parameter int BD_W    = mesh_skew_pkg::BD_W,
  parameter int ID_W    = mesh_skew_pkg::ID_W,
  parameter int SHIFT_W = mesh_skew_pkg::SHIFT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DIM*A_W-1:0]     in_a,
  input  logic [DIM*BD_W-1:0]    in_b,
  input  logic [DIM*BD_W-1:0]    in_d,
  input  logic [ID_W-1:0]        in_id,
  input  logic                   in_last,
  input  logic                   in_dataflow,
  input  logic                   in_propagate,
  input  logic [SHIFT_W-1:0]     in_shift,
  output logic [DIM-1:0]         out_valid,
  output logic [DIM*A_W-1:0]     out_a,
  output logic [DIM*BD_W-1:0]    out_b,
  output logic [DIM*BD_W-1:0]    out_d,
  output logic [DIM*ID_W-1:0]    out_id,
  output logic [DIM-1:0]         out_last,
  output logic [DIM-1:0]         out_dataflow,
  output logic [DIM-1:0]         out_propagate,
  output logic [DIM*SHIFT_W-1:0] out_shift,
  output logic                   busy
);

  import mesh_skew_pkg::*;

  // Same layout as the package records, but sized by this instance's parameters.
  typedef struct packed {
    logic               dataflow;
    logic               propagate;
    logic [SHIFT_W-1:0] shift;
  } lane_ctrl_t;

  typedef struct packed {
    logic            valid;
    logic [A_W-1:0]  a;
    logic [BD_W-1:0] b;
    logic [BD_W-1:0] d;
    logic [ID_W-1:0] id;
    logic            last;
    lane_ctrl_t      ctrl;
  } lane_t;

  localparam int               CNT_W    = $clog2(DIM + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIM);

  skew_state_e      r_state;
  skew_state_e      w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_fire;

  assign in_ready = (r_state != DRAIN);
  assign busy     = (r_state != IDLE);
  assign w_fire   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Drain lasts DIM cycles: long enough for the last beat to leave the deepest lane.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE, STREAM: begin
        if (w_fire) begin
          if (in_last) begin
            w_state_next = DRAIN;
            w_cnt_next   = CNT_LOAD;
          end else begin
            w_state_next = STREAM;
          end
        end
      end
      DRAIN: begin
        w_cnt_next = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
    lane_t w_lane_in;
    lane_t w_lane_out;

    assign w_lane_in = '{
      valid: w_fire,
      a:     in_a[gi*A_W +: A_W],
      b:     in_b[gi*BD_W +: BD_W],
      d:     in_d[gi*BD_W +: BD_W],
      id:    in_id,
      last:  in_last,
      ctrl:  '{dataflow: in_dataflow, propagate: in_propagate, shift: in_shift}
    };

    skew_delay_line #(
      .DEPTH (gi + 1),
      .T     (lane_t)
    ) u_delay (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (w_lane_in),
      .out_data (w_lane_out)
    );

    assign out_valid[gi]                   = w_lane_out.valid;
    assign out_a[gi*A_W +: A_W]            = w_lane_out.a;
    assign out_b[gi*BD_W +: BD_W]          = w_lane_out.b;
    assign out_d[gi*BD_W +: BD_W]          = w_lane_out.d;
    assign out_id[gi*ID_W +: ID_W]         = w_lane_out.id;
    assign out_last[gi]                    = w_lane_out.last;
    assign out_dataflow[gi]                = w_lane_out.ctrl.dataflow;
    assign out_propagate[gi]               = w_lane_out.ctrl.propagate;
    assign out_shift[gi*SHIFT_W +: SHIFT_W] = w_lane_out.ctrl.shift;
  end

endmodule

// File: tb/tb_mesh_input_skewer.sv
// Bench for mesh_input_skewer: a DIM=4 and a DIM=1 instance share the input pins and are
// compared against an edge-history reference model of the skew and drain rules.
module tb_mesh_input_skewer;

  localparam int D    = 4;
  localparam int A_W  = 8;
  localparam int BD_W = 20;
  localparam int ID_W = 3;
  localparam int SH_W = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic              in_valid, in_last, in_df, in_prop;
  logic [D*A_W-1:0]  in_a;
  logic [D*BD_W-1:0] in_b, in_d;
  logic [ID_W-1:0]   in_id;
  logic [SH_W-1:0]   in_shift;

  logic              in_ready4, busy4;
  logic [D-1:0]      o4_valid, o4_last, o4_df, o4_prop;
  logic [D*A_W-1:0]  o4_a;
  logic [D*BD_W-1:0] o4_b, o4_d;
  logic [D*ID_W-1:0] o4_id;
  logic [D*SH_W-1:0] o4_sh;

  logic              in_ready1, busy1;
  logic              o1_valid, o1_last, o1_df, o1_prop;
  logic [A_W-1:0]    o1_a;
  logic [BD_W-1:0]   o1_b, o1_d;
  logic [ID_W-1:0]   o1_id;
  logic [SH_W-1:0]   o1_sh;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mesh_input_skewer #(.DIM(D), .A_W(A_W), .BD_W(BD_W), .ID_W(ID_W), .SHIFT_W(SH_W)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b), .in_d(in_d), .in_id(in_id), .in_last(in_last),
    .in_dataflow(in_df), .in_propagate(in_prop), .in_shift(in_shift),
    .out_valid(o4_valid), .out_a(o4_a), .out_b(o4_b), .out_d(o4_d), .out_id(o4_id),
    .out_last(o4_last), .out_dataflow(o4_df), .out_propagate(o4_prop), .out_shift(o4_sh),
    .busy(busy4)
  );

  mesh_input_skewer #(.DIM(1), .A_W(A_W), .BD_W(BD_W), .ID_W(ID_W), .SHIFT_W(SH_W)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a[A_W-1:0]), .in_b(in_b[BD_W-1:0]), .in_d(in_d[BD_W-1:0]), .in_id(in_id),
    .in_last(in_last), .in_dataflow(in_df), .in_propagate(in_prop), .in_shift(in_shift),
    .out_valid(o1_valid), .out_a(o1_a), .out_b(o1_b), .out_d(o1_d), .out_id(o1_id),
    .out_last(o1_last), .out_dataflow(o1_df), .out_propagate(o1_prop), .out_shift(o1_sh),
    .busy(busy1)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic              fire;
    logic [D*A_W-1:0]  a;
    logic [D*BD_W-1:0] b;
    logic [D*BD_W-1:0] d;
    logic [ID_W-1:0]   id;
    logic              last;
    logic              df;
    logic              prop;
    logic [SH_W-1:0]   sh;
  } rec_t;

  typedef struct packed {
    logic            v;
    logic [A_W-1:0]  a;
    logic [BD_W-1:0] b;
    logic [BD_W-1:0] d;
    logic [ID_W-1:0] id;
    logic            last;
    logic            df;
    logic            prop;
    logic [SH_W-1:0] sh;
  } lane_t;

  rec_t hist[$];   // hist[0] = pins at the most recent edge
  rec_t hist1;
  int   drain4, drain1;
  bit   open4, open1;
  int   edge_no = 0;

  task automatic model_reset();
    rec_t z;
    z = '0;
    hist.delete();
    repeat (D) hist.push_front(z);
    hist1  = z;
    drain4 = 0;
    drain1 = 0;
    open4  = 1'b0;
    open1  = 1'b0;
  endtask

  function automatic lane_t exp4(int i);
    rec_t  r;
    lane_t e;
    r      = hist[i];
    e.v    = r.fire;
    e.a    = r.a[i*A_W +: A_W];
    e.b    = r.b[i*BD_W +: BD_W];
    e.d    = r.d[i*BD_W +: BD_W];
    e.id   = r.id;
    e.last = r.last;
    e.df   = r.df;
    e.prop = r.prop;
    e.sh   = r.sh;
    return e;
  endfunction

  function automatic lane_t got4(int i);
    lane_t g;
    g.v    = o4_valid[i];
    g.a    = o4_a[i*A_W +: A_W];
    g.b    = o4_b[i*BD_W +: BD_W];
    g.d    = o4_d[i*BD_W +: BD_W];
    g.id   = o4_id[i*ID_W +: ID_W];
    g.last = o4_last[i];
    g.df   = o4_df[i];
    g.prop = o4_prop[i];
    g.sh   = o4_sh[i*SH_W +: SH_W];
    return g;
  endfunction

  function automatic lane_t exp1();
    lane_t e;
    e.v    = hist1.fire;
    e.a    = hist1.a[A_W-1:0];
    e.b    = hist1.b[BD_W-1:0];
    e.d    = hist1.d[BD_W-1:0];
    e.id   = hist1.id;
    e.last = hist1.last;
    e.df   = hist1.df;
    e.prop = hist1.prop;
    e.sh   = hist1.sh;
    return e;
  endfunction

  function automatic lane_t got1();
    lane_t g;
    g = '{v: o1_valid, a: o1_a, b: o1_b, d: o1_d, id: o1_id, last: o1_last,
          df: o1_df, prop: o1_prop, sh: o1_sh};
    return g;
  endfunction

  // One clock edge: record the pins and each instance's accept decision, then settle.
  task automatic step();
    rec_t r;
    bit   f4, f1;
    f4 = in_valid && (drain4 == 0);
    f1 = in_valid && (drain1 == 0);
    @(posedge clk);
    r = '{fire: f4, a: in_a, b: in_b, d: in_d, id: in_id, last: in_last,
          df: in_df, prop: in_prop, sh: in_shift};
    hist.push_front(r);
    void'(hist.pop_back());
    hist1      = r;
    hist1.fire = f1;
    if (drain4 > 0) drain4--;
    else if (f4 && in_last) begin drain4 = D; open4 = 1'b0; end
    else if (f4) open4 = 1'b1;
    if (drain1 > 0) drain1--;
    else if (f1 && in_last) begin drain1 = 1; open1 = 1'b0; end
    else if (f1) open1 = 1'b1;
    edge_no++;
    #1;
  endtask

  task automatic rand_fields();
    for (int i = 0; i < D; i++) begin
      in_a[i*A_W +: A_W]   = A_W'($urandom);
      in_b[i*BD_W +: BD_W] = BD_W'($urandom);
      in_d[i*BD_W +: BD_W] = BD_W'($urandom);
    end
    in_id    = ID_W'($urandom);
    in_df    = 1'($urandom);
    in_prop  = 1'($urandom);
    in_shift = SH_W'($urandom);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++;
    if (o4_valid !== '0) begin errors++; $display("FAIL reset_valid4: got %b want 0", o4_valid); end
    checks++;
    if (in_ready4 !== 1'b1 || busy4 !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl4: ready=%b busy=%b want 1/0", in_ready4, busy4);
    end
    checks++;
    if (o1_valid !== 1'b0 || in_ready1 !== 1'b1 || busy1 !== 1'b0) begin
      errors++; $display("FAIL reset_dut1: valid=%b ready=%b busy=%b want 0/1/0", o1_valid, in_ready1, busy1);
    end
    for (int i = 0; i < D; i++) begin
      checks++;
      if (got4(i) !== exp4(i)) begin errors++; $display("FAIL reset_lane%0d: got %h want %h", i, got4(i), exp4(i)); end
    end
  endtask

  task automatic test_single_beat();
    logic [D-1:0] ev;
    rand_fields();
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_id    = 3'd5;
    for (int i = 0; i < D; i++) in_a[i*A_W +: A_W] = A_W'(i + 1);
    for (int k = 0; k < D + 2; k++) begin
      if (k == 1) begin in_valid = 1'b0; in_last = 1'b0; rand_fields(); end
      step();
      ev = (k < D) ? D'(1 << k) : '0;
      checks++;
      if (o4_valid !== ev) begin errors++; $display("FAIL single_valid k=%0d: got %b want %b", k, o4_valid, ev); end
      checks++;
      if (in_ready4 !== (k >= D)) begin errors++; $display("FAIL single_ready k=%0d: got %b want %b", k, in_ready4, (k >= D)); end
      if (k < D) begin
        checks++;
        if (o4_a[k*A_W +: A_W] !== A_W'(k + 1) || o4_id[k*ID_W +: ID_W] !== 3'd5) begin
          errors++; $display("FAIL single_data lane%0d: a=%0d id=%0d want a=%0d id=5", k, o4_a[k*A_W +: A_W], o4_id[k*ID_W +: ID_W], k + 1);
        end
      end
      for (int i = 0; i < D; i++) begin
        checks++;
        if (got4(i) !== exp4(i)) begin errors++; $display("FAIL single_lane%0d k=%0d: got %h want %h", i, k, got4(i), exp4(i)); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int vcnt[D];
    for (int i = 0; i < D; i++) vcnt[i] = 0;
    for (int k = 0; k < 8 + D + 2; k++) begin
      rand_fields();
      in_valid = (k < 8);
      in_last  = (k == 7);
      step();
      for (int i = 0; i < D; i++) begin
        vcnt[i] += int'(o4_valid[i]);
        checks++;
        if (got4(i) !== exp4(i)) begin errors++; $display("FAIL b2b_lane%0d k=%0d: got %h want %h", i, k, got4(i), exp4(i)); end
      end
      if (k < 8) begin
        checks++;
        if (busy4 !== 1'b1) begin errors++; $display("FAIL b2b_busy k=%0d: got %b want 1", k, busy4); end
      end
      if (k == 7) begin
        checks++;
        if (in_ready4 !== 1'b0) begin errors++; $display("FAIL b2b_drain: ready got %b want 0", in_ready4); end
      end
    end
    for (int i = 0; i < D; i++) begin
      checks++;
      if (vcnt[i] != 8) begin errors++; $display("FAIL b2b_count lane%0d: got %0d want 8", i, vcnt[i]); end
    end
  endtask

  task automatic test_bubble();
    for (int k = 0; k < D + 4; k++) begin
      rand_fields();
      in_valid = (k == 0 || k == 2);
      in_last  = (k == 2);
      step();
      for (int i = 0; i < D; i++) begin
        checks++;
        if (o4_valid[i] !== (k == i || k == i + 2)) begin
          errors++; $display("FAIL bubble_valid lane%0d k=%0d: got %b want %b", i, k, o4_valid[i], (k == i || k == i + 2));
        end
        checks++;
        if (got4(i) !== exp4(i)) begin errors++; $display("FAIL bubble_lane%0d k=%0d: got %h want %h", i, k, got4(i), exp4(i)); end
      end
    end
  endtask

  task automatic test_propagate();
    logic [A_W-1:0] a3 [3];
    for (int k = 0; k < D + 5; k++) begin
      rand_fields();
      in_valid = (k < 3);
      in_last  = (k == 2);
      if (k < 3) begin
        in_prop = k[0];
        a3[k]   = in_a[3*A_W +: A_W];
      end
      step();
      if (k >= 3 && k <= 5) begin
        checks++;
        if (o4_valid[3] !== 1'b1 || o4_prop[3] !== (k - 3 == 1) || o4_a[3*A_W +: A_W] !== a3[k-3]) begin
          errors++; $display("FAIL prop_lane3 k=%0d: v=%b prop=%b a=%h want 1/%b/%h", k, o4_valid[3], o4_prop[3], o4_a[3*A_W +: A_W], (k - 3 == 1), a3[k-3]);
        end
      end
      for (int i = 0; i < D; i++) begin
        checks++;
        if (got4(i) !== exp4(i)) begin errors++; $display("FAIL prop_lane%0d k=%0d: got %h want %h", i, k, got4(i), exp4(i)); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [D-1:0] ev;
    for (int k = 0; k < 3; k++) begin
      rand_fields();
      in_valid = 1'b1;
      in_last  = 1'b0;
      step();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (o4_valid !== '0 || o1_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_valid: dut4=%b dut1=%b want 0", o4_valid, o1_valid);
    end
    checks++;
    if (in_ready4 !== 1'b1 || busy4 !== 1'b0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL midrst_ctrl: ready4=%b busy4=%b busy1=%b want 1/0/0", in_ready4, busy4, busy1);
    end
    checks++;
    if (o4_a !== '0 || o4_b !== '0 || o4_d !== '0) begin
      errors++; $display("FAIL midrst_data: a=%h want 0", o4_a);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < D + 2; k++) begin
      rand_fields();
      in_valid = (k == 0);
      in_last  = (k == 0);
      step();
      ev = (k < D) ? D'(1 << k) : '0;
      checks++;
      if (o4_valid !== ev) begin errors++; $display("FAIL midrst_after k=%0d: got %b want %b", k, o4_valid, ev); end
      for (int i = 0; i < D; i++) begin
        checks++;
        if (got4(i) !== exp4(i)) begin errors++; $display("FAIL midrst_lane%0d k=%0d: got %h want %h", i, k, got4(i), exp4(i)); end
      end
    end
  endtask

  task automatic test_dim1();
    logic [A_W-1:0] a0;
    for (int k = 0; k < 4; k++) begin
      rand_fields();
      in_valid = (k < 3);
      in_last  = (k < 2);
      if (k == 0) a0 = in_a[A_W-1:0];
      step();
      if (k == 0) begin
        checks++;
        if (o1_valid !== 1'b1 || in_ready1 !== 1'b0 || o1_a !== a0) begin
          errors++; $display("FAIL dim1_accept: v=%b ready=%b a=%h want 1/0/%h", o1_valid, in_ready1, o1_a, a0);
        end
      end
      if (k == 1) begin
        checks++;
        if (o1_valid !== 1'b0 || in_ready1 !== 1'b1) begin
          errors++; $display("FAIL dim1_drain: v=%b ready=%b want 0/1", o1_valid, in_ready1);
        end
      end
      if (k == 2) begin
        checks++;
        if (o1_valid !== 1'b1 || busy1 !== 1'b1) begin
          errors++; $display("FAIL dim1_stream: v=%b busy=%b want 1/1", o1_valid, busy1);
        end
      end
      checks++;
      if (got1() !== exp1()) begin errors++; $display("FAIL dim1_lane k=%0d: got %h want %h", k, got1(), exp1()); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 80; k++) begin
      rand_fields();
      in_valid = ($urandom_range(0, 9) < 7);
      in_last  = ($urandom_range(0, 3) == 0);
      step();
      for (int i = 0; i < D; i++) begin
        checks++;
        if (got4(i) !== exp4(i)) begin errors++; $display("FAIL rand_lane%0d edge=%0d: got %h want %h", i, edge_no, got4(i), exp4(i)); end
      end
      checks++;
      if (in_ready4 !== (drain4 == 0) || busy4 !== (open4 || drain4 > 0)) begin
        errors++; $display("FAIL rand_ctrl4 edge=%0d: ready=%b busy=%b want %b/%b", edge_no, in_ready4, busy4, (drain4 == 0), (open4 || drain4 > 0));
      end
      checks++;
      if (got1() !== exp1() || in_ready1 !== (drain1 == 0) || busy1 !== (open1 || drain1 > 0)) begin
        errors++; $display("FAIL rand_dut1 edge=%0d: got %h r=%b b=%b want %h r=%b b=%b", edge_no, got1(), in_ready1, busy1, exp1(), (drain1 == 0), (open1 || drain1 > 0));
      end
    end
  endtask

  initial begin
    in_valid = 1'b0;
    in_last  = 1'b0;
    rand_fields();
    model_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_single_beat();
    test_back_to_back();
    test_bubble();
    test_propagate();
    test_reset_midflight();
    test_dim1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
